// File: rtl/proc_pkg.sv
// Shared processor constants: FSM state encoding and default datapath width.
// Imported by the register-write arbiter and its round-robin picker.
package proc_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Index width for n items; a single item still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner finder.
// Searches upward from ptr_i, wrapping at NUM_REQ-1.
module rr_pick
  import proc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   win_o,
  output logic               any_o
);

  logic [IDX_W-1:0] idx;

  // First set request at or after the pointer, in wrap order.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        win_o = idx;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of the register bank.
// Drives one registered load strobe and the shared write-data bus.
module reg_write_arbiter
  import proc_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REGS-1:0]        load,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       busy,
  output logic                       addr_err
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [0:0]          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REGS-1:0] load_q, load_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                addr_err_q, addr_err_d;

  logic [IDX_W-1:0]    win;
  logic                any_req;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

  // Mux the winner's address and data slices.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state: arbitrate only in IDLE; GRANT always falls back.
  always_comb begin
    state_d    = IDLE;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    load_d     = '0;
    wr_data_d  = wr_data_q;
    addr_err_d = 1'b0;
    if (state_q == IDLE && any_req) begin
      state_d   = GRANT;
      wr_data_d = sel_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_d[i] = (win == IDX_W'(i));
      end
      if (32'(sel_addr) < NUM_REGS) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          load_d[r] = (sel_addr == ADDR_W'(r));
        end
      end else begin
        addr_err_d = 1'b1;
      end
      if (32'(win) == NUM_REQ - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win + IDX_W'(1);
      end
    end
  end

  // State and registered outputs; reset drops any pending load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      load_q     <= '0;
      wr_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      load_q     <= load_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign gnt      = gnt_q;
  assign load     = load_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q == GRANT);
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter.
// Second instance with three registers exercises the address-error path.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  load;
  logic [7:0]  wr_data;
  logic        busy;
  logic        addr_err;

  logic [3:0]  req_b;
  logic [7:0]  req_addr_b;
  logic [31:0] req_data_b;
  logic [3:0]  gnt_b;
  logic [2:0]  load_b;
  logic [7:0]  wr_data_b;
  logic        busy_b;
  logic        addr_err_b;

  logic [7:0]  regs [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(
    .NUM_REQ(4), .NUM_REGS(4), .DATA_W(8), .ADDR_W(2)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .load(load),
    .wr_data(wr_data), .busy(busy), .addr_err(addr_err)
  );

  reg_write_arbiter #(
    .NUM_REQ(4), .NUM_REGS(3), .DATA_W(8), .ADDR_W(2)
  ) u_dut3 (
    .clk(clk), .rst(rst), .req(req_b), .req_addr(req_addr_b),
    .req_data(req_data_b), .gnt(gnt_b), .load(load_b),
    .wr_data(wr_data_b), .busy(busy_b), .addr_err(addr_err_b)
  );

  // Register bank stand-in: captures wr_data on its load pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 4; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < 4; r++) if (load[r]) regs[r] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req = '0; req_addr = '0; req_data = '0;
    req_b = '0; req_addr_b = '0; req_data_b = '0;
    tick(); tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_load", 32'(load), 0);
    check("rst_wdata", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_aerr", 32'(addr_err), 0);
    rst = 1'b1;

    // single write: req1 -> reg2
    req      = 4'b0010;
    req_addr = {2'd0, 2'd0, 2'd2, 2'd0};
    req_data = {8'h00, 8'h00, 8'hA5, 8'h00};
    tick();
    check("sw_gnt", 32'(gnt), 32'b0010);
    check("sw_load", 32'(load), 32'b0100);
    check("sw_wdata", 32'(wr_data), 32'hA5);
    check("sw_busy", 32'(busy), 1);
    check("sw_aerr", 32'(addr_err), 0);
    req = '0;
    tick();
    check("sw_idle_busy", 32'(busy), 0);
    check("sw_idle_load", 32'(load), 0);
    check("sw_hold_wdata", 32'(wr_data), 32'hA5);
    check("sw_reg2", 32'(regs[2]), 32'hA5);

    // req3 -> reg2, then async reset mid-GRANT
    req      = 4'b1000;
    req_addr = {2'd2, 2'd0, 2'd0, 2'd0};
    req_data = {8'h5A, 8'h00, 8'h00, 8'h00};
    tick();
    check("rg_gnt", 32'(gnt), 32'b1000);
    check("rg_load", 32'(load), 32'b0100);
    #3 rst = 1'b0;
    #1;
    check("rg_async_gnt", 32'(gnt), 0);
    check("rg_async_load", 32'(load), 0);
    check("rg_async_busy", 32'(busy), 0);
    check("rg_reg2_clr", 32'(regs[2]), 0);

    // all requesting: rotation 0,1,2,3,0 from a fresh pointer
    req      = 4'b1111;
    req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    #2 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      check("rr_load", 32'(load), 32'(1 << (k % 4)));
      check("rr_wdata", 32'(wr_data), 32'(8'h10 + k % 4));
      check("rr_busy1", 32'(busy), 1);
      tick();
      check("rr_busy0", 32'(busy), 0);
      check("rr_gnt0", 32'(gnt), 0);
    end
    check("rr_reg1", 32'(regs[1]), 32'h11);
    check("rr_reg3", 32'(regs[3]), 32'h13);

    // pointer wrap: grant req3, then 1001 -> 0 then 3
    req = 4'b1000;
    tick();
    check("wr_g3", 32'(gnt), 32'b1000);
    req = 4'b1001;
    tick();
    check("wr_idle1", 32'(gnt), 0);
    tick();
    check("wr_g0", 32'(gnt), 32'b0001);
    req = 4'b1000;
    tick();
    check("wr_idle2", 32'(gnt), 0);
    tick();
    check("wr_g3b", 32'(gnt), 32'b1000);
    req = '0;
    tick();

    // req2 appearing during GRANT waits for the next IDLE
    req = 4'b0001;
    tick();
    check("ig_g0", 32'(gnt), 32'b0001);
    req = 4'b0100;
    tick();
    check("ig_not_gnt", 32'(gnt), 0);
    check("ig_busy0", 32'(busy), 0);
    tick();
    check("ig_g2", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    check("ig_end", 32'(busy), 0);

    // out-of-range address on the three-register instance
    req_b      = 4'b0001;
    req_addr_b = {2'd0, 2'd0, 2'd0, 2'd3};
    req_data_b = {8'h00, 8'h00, 8'h00, 8'hEE};
    tick();
    check("oor_gnt", 32'(gnt_b), 32'b0001);
    check("oor_load", 32'(load_b), 0);
    check("oor_aerr", 32'(addr_err_b), 1);
    check("oor_wdata", 32'(wr_data_b), 32'hEE);
    check("oor_busy", 32'(busy_b), 1);
    req_b = '0;
    tick();
    check("oor_aerr_clr", 32'(addr_err_b), 0);
    check("oor_gnt_clr", 32'(gnt_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
